adsr_envelope: RTL

Per-voice ADSR amplitude envelope generator and sample scaler. It sits between the MIDI interface and the carrier input of the filterbank. It takes the note gate and velocity from the MIDI interface plus the raw synthesizer sample stream, and outputs a velocity- and envelope-scaled carrier sample. It replaces the unused fixed-volume scaling path on the carrier.

---
 rtl/adsr_envelope.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/adsr_envelope.sv
//==============================================================================
// Module   : adsr_envelope
// Purpose  : Per-voice ADSR amplitude envelope generator with a two-stage
//            sample scaler. It sits between the MIDI interface and the
//            filterbank carrier input.
// Ports    : clk_in, rst_in (sync, active-low), tick_in (envelope step strobe)
//            gate_in / vel_in (note gate and velocity)
//            attack/decay/release rates and sustain level
//            sample_in / sample_valid_in  -> sample_out / valid_out (2-cycle latency)
//            env_out, state_out, busy_out (envelope status)
// Config   : ADSR_EXP_RELEASE_EN selects exponential release
//            (lvl -= (lvl >> release_rate_in[3:0]) + 1); linear release otherwise.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module adsr_envelope #(
  parameter int WIDTH     = 24,
  parameter int ENV_BITS  = 16,
  parameter int RATE_BITS = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        tick_in,
  input  logic                        gate_in,
  input  logic [6:0]                  vel_in,
  input  logic [RATE_BITS-1:0]        attack_rate_in,
  input  logic [RATE_BITS-1:0]        decay_rate_in,
  input  logic [ENV_BITS-1:0]         sustain_in,
  input  logic [RATE_BITS-1:0]        release_rate_in,
  input  logic signed [WIDTH-1:0]     sample_in,
  input  logic                        sample_valid_in,
  output logic signed [WIDTH-1:0]     sample_out,
  output logic                        valid_out,
  output logic [ENV_BITS-1:0]         env_out,
  output logic [2:0]                  state_out,
  output logic                        busy_out
);

  // Level arithmetic is one bit wider than the level so that overflow past
  // full scale and underflow below zero are both visible in the top bit.
  localparam int EW = ENV_BITS + 1;
  localparam int PW = WIDTH + ENV_BITS + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  state_e                 state_q;
  logic [ENV_BITS-1:0]    lvl_q;
  logic [ENV_BITS-1:0]    peak_q;
  logic [ENV_BITS-1:0]    sus_q;
  logic                   gate_q;

  logic                   gate_rise;
  logic                   gate_fall;
  logic [ENV_BITS-1:0]    peak_d;
  logic [ENV_BITS-1:0]    sus_d;
  logic [EW-1:0]          atk_sum;
  logic [EW-1:0]          dec_diff;
  logic [EW-1:0]          rel_diff;
  logic                   atk_done;
  logic                   dec_done;
  logic                   rel_done;

  assign gate_rise = gate_in & ~gate_q;
  assign gate_fall = ~gate_in & gate_q;

  // Velocity is replicated so that 127 reaches exact full scale.
  assign peak_d = ENV_BITS'({vel_in, vel_in, vel_in[6:5]});
  assign sus_d  = (sustain_in < peak_d) ? sustain_in : peak_d;

  assign atk_sum  = {1'b0, lvl_q} + EW'(attack_rate_in);
  assign atk_done = (attack_rate_in == '0) || (atk_sum >= {1'b0, peak_q});

  // Top bit of the difference set means the subtraction went below zero.
  assign dec_diff = {1'b0, lvl_q} - EW'(decay_rate_in);
  assign dec_done = (decay_rate_in == '0) || dec_diff[EW-1] ||
                    (dec_diff[ENV_BITS-1:0] <= sus_q);

`ifdef ADSR_EXP_RELEASE_EN
  logic [EW-1:0] rel_step;
  assign rel_step = EW'(lvl_q >> release_rate_in[3:0]) + EW'(1'b1);
  assign rel_diff = {1'b0, lvl_q} - rel_step;
`else
  assign rel_diff = {1'b0, lvl_q} - EW'(release_rate_in);
`endif
  assign rel_done = (release_rate_in == '0) || rel_diff[EW-1] || (rel_diff == '0);

  // Envelope state machine. Gate edges take priority over a coincident tick;
  // a rising edge with zero velocity is treated as no edge at all.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      lvl_q   <= '0;
      peak_q  <= '0;
      sus_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      gate_q <= gate_in;
      if (gate_rise && (vel_in != 7'd0)) begin
        // Retrigger keeps the current level; attack resumes from there.
        peak_q  <= peak_d;
        sus_q   <= sus_d;
        state_q <= ST_ATTACK;
      end else if (gate_fall && ((state_q == ST_ATTACK) || (state_q == ST_DECAY) ||
                                 (state_q == ST_SUSTAIN))) begin
        state_q <= ST_RELEASE;
      end else if (tick_in) begin
        case (state_q)
          ST_ATTACK: begin
            if (atk_done) begin
              lvl_q   <= peak_q;
              state_q <= ST_DECAY;
            end else begin
              lvl_q <= atk_sum[ENV_BITS-1:0];
            end
          end
          ST_DECAY: begin
            if (dec_done) begin
              lvl_q   <= sus_q;
              state_q <= ST_SUSTAIN;
            end else begin
              lvl_q <= dec_diff[ENV_BITS-1:0];
            end
          end
          ST_SUSTAIN: begin
            lvl_q <= lvl_q;
          end
          ST_RELEASE: begin
            if (rel_done) begin
              lvl_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              lvl_q <= rel_diff[ENV_BITS-1:0];
            end
          end
          default: begin
            lvl_q   <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Scaling pipeline: stage 1 multiplies by the level as it stood before any
  // same-cycle tick update; stage 2 takes an arithmetic shift (floor).
  logic signed [PW-1:0]    smp_ext;
  logic signed [PW-1:0]    lvl_ext;
  logic signed [PW-1:0]    prod_d;
  logic signed [PW-1:0]    prod_q;
  logic                    v1_q;
  logic                    vout_q;
  logic signed [WIDTH-1:0] smp_q;
  logic                    unused_prod_bits;

  assign smp_ext = {{(ENV_BITS + 1){sample_in[WIDTH-1]}}, sample_in};
  assign lvl_ext = {{(WIDTH + 1){1'b0}}, lvl_q};
  assign prod_d  = smp_ext * lvl_ext;

  // Fraction bits and the redundant sign bit are dropped by the shift/truncate.
  assign unused_prod_bits = ^{prod_q[ENV_BITS-1:0], prod_q[PW-1]};

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      prod_q <= '0;
      v1_q   <= 1'b0;
      vout_q <= 1'b0;
      smp_q  <= '0;
    end else begin
      v1_q   <= sample_valid_in;
      vout_q <= v1_q;
      if (sample_valid_in) begin
        prod_q <= prod_d;
      end
      if (v1_q) begin
        smp_q <= prod_q[ENV_BITS +: WIDTH];
      end
    end
  end

  assign sample_out = smp_q;
  assign valid_out  = vout_q;
  assign env_out    = lvl_q;
  assign state_out  = state_q;
  assign busy_out   = (state_q != ST_IDLE);

endmodule

`default_nettype wire
